// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: IF -> fetch queue -> ID handshake bundle plus pipeline flush.
// master = pipeline side (IF/ID/flush source), slave = the queue.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int BUS_W = 69
);
    logic                         flush;
    logic                         fs_to_fq_valid;
    logic [BUS_W-1:0]             fs_to_fq_bus;
    logic                         fq_allow_in;
    logic                         ds_allow_in;
    logic                         fq_to_ds_valid;
    logic [BUS_W-1:0]             fq_to_ds_bus;
    logic [$clog2(DEPTH+1)-1:0]   fq_count;

    modport master (
        output flush, fs_to_fq_valid, fs_to_fq_bus, ds_allow_in,
        input  fq_allow_in, fq_to_ds_valid, fq_to_ds_bus, fq_count
    );
    modport slave (
        input  flush, fs_to_fq_valid, fs_to_fq_bus, ds_allow_in,
        output fq_allow_in, fq_to_ds_valid, fq_to_ds_bus, fq_count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: IF-to-ID decoupling FIFO with flush.
// Optional INST_FQ_EXC_STOP_EN: stall IF after a word carrying fetch exception flags.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int BUS_W = 69
) (
    input logic               clk,
    input logic               resetn,
    inst_fetch_queue_if.slave fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             push, pop, full, stop;

`ifdef INST_FQ_EXC_STOP_EN
    logic exc_stop;
    assign stop = exc_stop;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) exc_stop <= 1'b0;
        else if (fq.flush) exc_stop <= 1'b0;
        else if (push && (|fq.fs_to_fq_bus[68:66] || fq.fs_to_fq_bus[64])) exc_stop <= 1'b1;
`else
    assign stop = 1'b0;
`endif

    // allow_in ignores ds_allow_in so no combinational IF/ID loop forms
    assign full              = count == CW'(DEPTH);
    assign fq.fq_allow_in    = resetn & ~fq.flush & ~full & ~stop;
    assign fq.fq_to_ds_valid = (count != '0) & ~fq.flush;
    assign fq.fq_to_ds_bus   = mem[rd_ptr];
    assign fq.fq_count       = count;
    assign push              = fq.fs_to_fq_valid & fq.fq_allow_in;
    assign pop               = fq.fq_to_ds_valid & fq.ds_allow_in;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= fq.fs_to_fq_bus;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table-driven checks of inst_fetch_queue handshake/occupancy,
// with a scoreboard queue checking popped data order.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int BUS_W = 69;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int nvec = 0;
    int nmiss = 0;
    logic [BUS_W-1:0] sb[$];
    logic stop_m = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .BUS_W(BUS_W)) f ();
    inst_fetch_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (.clk(clk), .resetn(resetn), .fq(f));

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ds;
        logic        fl;
        logic        ea;
        logic        ev;
        int          ec;
    } vec_t;

    function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic [4:0] flags);
        return {flags, ~pc, pc};
    endfunction

    task automatic chk(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // drive one cycle from just after a negedge, check, update the model at the posedge
    task automatic step(input logic v, input logic [BUS_W-1:0] w, input logic ds, input logic fl,
                        input logic ea, input logic ev, input int ec, input string nm);
        logic m_push, m_pop;
        f.fs_to_fq_valid = v;
        f.fs_to_fq_bus   = w;
        f.ds_allow_in    = ds;
        f.flush          = fl;
        #1;
        chk({nm, ".allow"}, BUS_W'(f.fq_allow_in), BUS_W'(ea));
        chk({nm, ".valid"}, BUS_W'(f.fq_to_ds_valid), BUS_W'(ev));
        chk({nm, ".count"}, BUS_W'(f.fq_count), BUS_W'(ec));
        m_push = v && !fl && sb.size() < DEPTH && !stop_m;
        m_pop  = ds && !fl && sb.size() > 0;
        if (m_pop) chk({nm, ".data"}, f.fq_to_ds_bus, sb[0]);
        @(posedge clk);
        if (fl) begin
            sb.delete();
            stop_m = 1'b0;
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                sb.push_back(w);
`ifdef INST_FQ_EXC_STOP_EN
                if (|w[68:66] || w[64]) stop_m = 1'b1;
`endif
            end
        end
        @(negedge clk);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'h1C000000, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 32'h1C000004, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[2] = '{1'b1, 32'h1C000008, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        tbl[3] = '{1'b1, 32'h1C00000C, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        tbl[4] = '{1'b1, 32'h1C000010, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[5] = '{1'b1, 32'h1C000010, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 3};
        tbl[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 0};

        f.fs_to_fq_valid = 1'b0;
        f.fs_to_fq_bus   = '0;
        f.ds_allow_in    = 1'b0;
        f.flush          = 1'b0;
        @(negedge clk);
        chk("rst.allow", BUS_W'(f.fq_allow_in), '0);
        chk("rst.valid", BUS_W'(f.fq_to_ds_valid), '0);
        chk("rst.count", BUS_W'(f.fq_count), '0);
        @(negedge clk);
        resetn = 1'b1;

        // fill to full, refuse a fifth word, then drain in order
        for (int i = 0; i < 10; i++)
            step(tbl[i].v, mk(tbl[i].pc, 5'b0), tbl[i].ds, tbl[i].fl,
                 tbl[i].ea, tbl[i].ev, tbl[i].ec, $sformatf("tbl%0d", i));

        // streaming: occupancy settles at 1, pointers wrap several times
        for (int i = 0; i < 20; i++)
            step(1'b1, mk(32'h1C000100 + 32'(4 * i), 5'b0), 1'b1, 1'b0,
                 1'b1, i != 0, i != 0 ? 1 : 0, $sformatf("stream%0d", i));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1, "stream_drain");
        chk("stream_empty", BUS_W'(sb.size()), '0);

        // flush at count 3 with IF still offering
        step(1'b1, mk(32'h1C000200, 5'b0), 1'b0, 1'b0, 1'b1, 1'b0, 0, "fl_fill0");
        step(1'b1, mk(32'h1C000204, 5'b0), 1'b0, 1'b0, 1'b1, 1'b1, 1, "fl_fill1");
        step(1'b1, mk(32'h1C000208, 5'b0), 1'b0, 1'b0, 1'b1, 1'b1, 2, "fl_fill2");
        step(1'b1, mk(32'h1C00020C, 5'b0), 1'b1, 1'b1, 1'b0, 1'b0, 3, "fl_flush");
        step(1'b1, mk(32'h1C008000, 5'b0), 1'b0, 1'b0, 1'b1, 1'b0, 0, "fl_push");
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1, "fl_head");

        // multi-cycle flush keeps the queue empty and closed
        step(1'b1, mk(32'h1C000300, 5'b0), 1'b0, 1'b0, 1'b1, 1'b0, 0, "mfl_push");
        step(1'b1, mk(32'h1C000304, 5'b0), 1'b1, 1'b1, 1'b0, 1'b0, 1, "mfl0");
        step(1'b1, mk(32'h1C000308, 5'b0), 1'b1, 1'b1, 1'b0, 1'b0, 0, "mfl1");
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "mfl_after");

        // asynchronous reset mid-stream at count 2
        step(1'b1, mk(32'h1C000400, 5'b0), 1'b0, 1'b0, 1'b1, 1'b0, 0, "ar0");
        step(1'b1, mk(32'h1C000404, 5'b0), 1'b0, 1'b0, 1'b1, 1'b1, 1, "ar1");
        f.fs_to_fq_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("ar.valid", BUS_W'(f.fq_to_ds_valid), '0);
        chk("ar.count", BUS_W'(f.fq_count), '0);
        chk("ar.allow", BUS_W'(f.fq_allow_in), '0);
        sb.delete();
        stop_m = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "ar_after");

        // exception-flagged word: stops IF only with the stop feature
        step(1'b1, mk(32'h1C000002, 5'b00001), 1'b0, 1'b0, 1'b1, 1'b0, 0, "exc_push");
`ifdef INST_FQ_EXC_STOP_EN
        step(1'b1, mk(32'h1C000006, 5'b0), 1'b1, 1'b0, 1'b0, 1'b1, 1, "exc_stall");
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "exc_drained");
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "exc_flush");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "exc_reopen");
`else
        step(1'b1, mk(32'h1C000006, 5'b0), 1'b1, 1'b0, 1'b1, 1'b1, 1, "exc_cont");
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1, "exc_drain");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "exc_empty");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
